substitution_layer: RTL and testbench

SUBSTITUTION_LAYER -- requirements
Module: substitution_layer

---
 rtl/ascon_pkg.sv | 10 +
 rtl/ascon_sbox5.sv | 22 ++
 rtl/substitution_layer.sv | 58 +++++
 tb/tb_substitution_layer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon types and widths used by the substitution layer and the permutation blocks.
package ascon_pkg;

  localparam int WORD_WIDTH = 64;
  localparam int NUM_WORDS  = 5;

  // Indexed [word][bit]; word w is lane Sw.
  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;

endpackage

// File: rtl/ascon_sbox5.sv
// Ascon 5-bit S-box in algebraic normal form, one bit column of the state.
module ascon_sbox5 (
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);

  logic x0, x1, x2, x3, x4;

  // x0 sits in the MSB so the column value reads like the published S-box index.
  assign x0 = x_i[4];
  assign x1 = x_i[3];
  assign x2 = x_i[2];
  assign x3 = x_i[1];
  assign x4 = x_i[0];

  assign y_o[4] = (x4 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ (x1 & x0) ^ x1 ^ x0;
  assign y_o[3] = x4 ^ (x3 & x2) ^ (x3 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ x1 ^ x0;
  assign y_o[2] = (x4 & x3) ^ x4 ^ x2 ^ x1 ^ 1'b1;
  assign y_o[1] = (x4 & x0) ^ x4 ^ (x3 & x0) ^ x3 ^ x2 ^ x1 ^ x0;
  assign y_o[0] = (x4 & x1) ^ x4 ^ x3 ^ (x1 & x0) ^ x1;

endmodule

// File: rtl/substitution_layer.sv
// Ascon substitution layer: combinational S-box over every bit column plus a registered copy.
module substitution_layer
  import ascon_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  ascon_state_t state_array_i,
  input  logic         valid_i,
  output ascon_state_t state_array_o,
  output ascon_state_t state_array_q,
  output logic         valid_o
);

  ascon_state_t sbox_out;
  ascon_state_t state_array_d;
  logic         valid_d;
  logic         valid_q;

  for (genvar j = 0; j < WORD_WIDTH; j++) begin : g_col
    logic [4:0] col_y;

    ascon_sbox5 u_sbox (
      .x_i ({state_array_i[0][j], state_array_i[1][j], state_array_i[2][j],
             state_array_i[3][j], state_array_i[4][j]}),
      .y_o (col_y)
    );

    assign sbox_out[0][j] = col_y[4];
    assign sbox_out[1][j] = col_y[3];
    assign sbox_out[2][j] = col_y[2];
    assign sbox_out[3][j] = col_y[1];
    assign sbox_out[4][j] = col_y[0];
  end

  assign state_array_o = sbox_out;
  assign valid_o       = valid_q;

  // Idle cycles keep the last result but drop valid.
  always_comb begin
    state_array_d = state_array_q;
    valid_d       = 1'b0;
    if (valid_i) begin
      state_array_d = sbox_out;
      valid_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_array_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_array_q <= state_array_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_substitution_layer.sv
// Directed and random checks of the Ascon substitution layer, combinational and registered paths.
module tb_substitution_layer;
  import ascon_pkg::*;

  logic         clk;
  logic         rst;
  ascon_state_t stateIn;
  logic         validIn;
  ascon_state_t stateComb;
  ascon_state_t stateReg;
  logic         validOut;

  int testCount = 0;
  int failCount = 0;

  // Published Ascon S-box, index has x0 as MSB.
  logic [4:0] sboxTable [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  substitution_layer dut (
    .clk           (clk),
    .rst           (rst),
    .state_array_i (stateIn),
    .valid_i       (validIn),
    .state_array_o (stateComb),
    .state_array_q (stateReg),
    .valid_o       (validOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-lane bitwise reference of the S-box equations.
  function automatic ascon_state_t sboxModel(input ascon_state_t s);
    logic [63:0] x0, x1, x2, x3, x4;
    ascon_state_t r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    r[0] = (x4 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ (x1 & x0) ^ x1 ^ x0;
    r[1] = x4 ^ (x3 & x2) ^ (x3 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ x1 ^ x0;
    r[2] = (x4 & x3) ^ x4 ^ x2 ^ x1 ^ {64{1'b1}};
    r[3] = (x4 & x0) ^ x4 ^ (x3 & x0) ^ x3 ^ x2 ^ x1 ^ x0;
    r[4] = (x4 & x1) ^ x4 ^ x3 ^ (x1 & x0) ^ x1;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] actual,
                             input logic [319:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input ascon_state_t s, input logic v, input logic r);
    stateIn = s;
    validIn = v;
    rst     = r;
    #1;
  endtask

  ascon_state_t stim;
  ascon_state_t expState;
  ascon_state_t vec [5];
  logic [4:0]   tv;

  initial begin
    stateIn = '0;
    validIn = 1'b0;
    rst     = 1'b1;

    // Reset with valid_i high must still clear the registered path.
    @(posedge clk); #1;
    applyStimulus('0, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("reset_q", stateReg, '0);
    checkOutput("reset_valid", {319'd0, validOut}, 320'd0);

    // Column-0 sweep over a zero background.
    for (int x = 0; x < 32; x++) begin
      stim = '0;
      for (int w = 0; w < 5; w++) stim[w][0] = x[4-w];
      applyStimulus(stim, 1'b0, 1'b1);
      tv = sboxTable[x];
      expState = '0;
      expState[2] = {64{1'b1}};
      for (int w = 0; w < 5; w++) expState[w][0] = tv[4-w];
      checkOutput($sformatf("sweep_%0d", x), stateComb, expState);
    end

    applyStimulus('0, 1'b0, 1'b1);
    expState = '0;
    expState[2] = 64'hFFFFFFFFFFFFFFFF;
    checkOutput("all_zero", stateComb, expState);

    stim = '0;
    stim[4] = 64'h0000000000000001;
    applyStimulus(stim, 1'b0, 1'b1);
    expState[0] = 64'h0;
    expState[1] = 64'h1;
    expState[2] = 64'hFFFFFFFFFFFFFFFE;
    expState[3] = 64'h1;
    expState[4] = 64'h1;
    checkOutput("s4_lsb", stateComb, expState);

    applyStimulus('1, 1'b0, 1'b1);
    expState[0] = 64'hFFFFFFFFFFFFFFFF;
    expState[1] = 64'h0;
    expState[2] = 64'hFFFFFFFFFFFFFFFF;
    expState[3] = 64'hFFFFFFFFFFFFFFFF;
    expState[4] = 64'hFFFFFFFFFFFFFFFF;
    checkOutput("all_ones", stateComb, expState);

    for (int n = 0; n < 500; n++) begin
      for (int w = 0; w < 5; w++) stim[w] = {$urandom, $urandom};
      applyStimulus(stim, 1'b0, 1'b1);
      checkOutput($sformatf("random_%0d", n), stateComb, sboxModel(stim));
      if (failCount != 0) begin
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $fatal(1, "[TB] stopping on first random error");
      end
    end

    for (int k = 0; k < 5; k++)
      for (int w = 0; w < 5; w++) vec[k][w] = {$urandom, $urandom};

    // Registered path: three valid beats, an idle beat, then a mid-stream reset.
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(vec[k], 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput($sformatf("reg_q_%0d", k), stateReg, sboxModel(vec[k]));
      checkOutput($sformatf("reg_valid_%0d", k), {319'd0, validOut}, 320'd1);
    end

    applyStimulus(vec[3], 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("hold_q", stateReg, sboxModel(vec[2]));
    checkOutput("hold_valid", {319'd0, validOut}, 320'd0);

    applyStimulus(vec[4], 1'b1, 1'b1);
    checkOutput("comb_in_reset", stateComb, sboxModel(vec[4]));
    @(posedge clk); #1;
    checkOutput("midreset_q", stateReg, '0);
    checkOutput("midreset_valid", {319'd0, validOut}, 320'd0);

    applyStimulus(vec[4], 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("post_reset_q", stateReg, '0);
    checkOutput("post_reset_valid", {319'd0, validOut}, 320'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
